// File: rtl/uart_word_tx_pkg.sv
// Shared types and constants for the word UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    GAP   = 3'd4
  } tx_state_t;

  localparam int BYTES_PER_WORD       = 4;
  localparam int DEF_CLK_PER_HALF_BIT = 30;

  // One bit period in clk cycles.
  function automatic int bit_period(input int half_bit);
    return 2 * half_bit;
  endfunction

  // Little-endian byte select from a word.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_word_tx_if.sv
// Push-side handshake between the core and the word transmitter.
interface uart_word_tx_if;
  logic [31:0] send_data;
  logic [1:0]  core_sig;
  logic        output_stall;
  logic        output_ready;

  modport master (
    output send_data,
    output core_sig,
    input  output_stall,
    input  output_ready
  );

  modport slave (
    input  send_data,
    input  core_sig,
    output output_stall,
    output output_ready
  );
endinterface

// File: rtl/uart_word_tx_sync_word_fifo.sv
// Single-clock word FIFO with registered full/empty. The head word is
// presented combinationally so the consumer can latch it in the cycle it pops.
module sync_word_fifo #(
  parameter int WIDTH = 33,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW:0]      w_count_next;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;

  // A push while full is dropped; a pop while empty is ignored.
  assign w_push = i_wr_en && !r_full;
  assign w_pop  = i_rd_en && !r_empty;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_full  <= (w_count_next == (AW+1)'(DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;
endmodule

// File: rtl/uart_word_tx.sv
// Word UART transmitter: buffers 1- or 4-byte pushes and sends them as 8N1
// frames, pausing between bytes while the host holds cts_n high.
//
//  state | meaning
//  IDLE  | waiting for a FIFO entry and clear-to-send; pops and latches the head
//  START | start bit (txd=0) for one bit period
//  DATA  | 8 data bits, LSB first
//  STOP  | stop bit (txd=1); byte counted at its end
//  GAP   | between bytes of a word, holding txd=1 until clear-to-send
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = DEF_CLK_PER_HALF_BIT,
  parameter int FIFO_AW          = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_word_tx_if.slave bus,
  input  logic          i_cts_n,
  output logic          o_txd,
  output logic [31:0]   o_data_count
);
  localparam int BIT_PERIOD = bit_period(CLK_PER_HALF_BIT);
  localparam int CNT_W      = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;

  logic             r_cts_meta;
  logic             r_cts_sync;
  tx_state_t        r_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [2:0]       r_bit_idx;
  logic [1:0]       r_byte_idx;
  logic [32:0]      r_word;
  logic             r_txd;
  logic [31:0]      r_data_count;
  logic             r_ready;

  logic [32:0]      w_rd_data;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_bit_end;
  logic [7:0]       w_cur_byte;
  logic             w_more_bytes;

  sync_word_fifo #(
    .WIDTH (33),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (bus.core_sig[1]),
    .i_wr_data ({bus.core_sig[0], bus.send_data}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Two-flop synchroniser for the asynchronous host flow-control input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cts_meta <= 1'b1;
      r_cts_sync <= 1'b1;
    end else begin
      r_cts_meta <= i_cts_n;
      r_cts_sync <= r_cts_meta;
    end
  end

  assign w_pop        = (r_state == IDLE) && !w_empty && !r_cts_sync;
  assign w_bit_end    = (r_bit_cnt == CNT_W'(BIT_PERIOD - 1));
  assign w_cur_byte   = word_byte(r_word[31:0], r_byte_idx);
  assign w_more_bytes = r_word[32] && (r_byte_idx < 2'(BYTES_PER_WORD - 1));

  // Frame sequencer with bit timer, byte counter and registered txd.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_bit_idx    <= '0;
      r_byte_idx   <= '0;
      r_word       <= '0;
      r_txd        <= 1'b1;
      r_data_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_txd <= 1'b1;
          if (w_pop) begin
            r_word     <= w_rd_data;
            r_byte_idx <= '0;
            r_bit_cnt  <= '0;
            r_txd      <= 1'b0;
            r_state    <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_txd     <= w_cur_byte[0];
            r_state   <= DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_txd     <= w_cur_byte[r_bit_idx + 3'd1];
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_bit_cnt    <= '0;
            r_data_count <= r_data_count + 32'd1;
            if (w_more_bytes) begin
              r_byte_idx <= r_byte_idx + 2'd1;
              // GAP is a pass-through when the host is already clear.
              if (!r_cts_sync) begin
                r_txd   <= 1'b0;
                r_state <= START;
              end else begin
                r_state <= GAP;
              end
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        GAP: begin
          r_txd <= 1'b1;
          if (!r_cts_sync) begin
            r_bit_cnt <= '0;
            r_txd     <= 1'b0;
            r_state   <= START;
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Ready when nothing is queued and no frame is in flight.
  always_ff @(posedge clk) begin
    if (rst) r_ready <= 1'b1;
    else     r_ready <= w_empty && (r_state == IDLE);
  end

  assign o_txd            = r_txd;
  assign o_data_count     = r_data_count;
  assign bus.output_stall = w_full;
  assign bus.output_ready = r_ready;
endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx with CLK_PER_HALF_BIT=2 (4 cycles per bit).
module tb_uart_word_tx;
  logic        clk = 1'b0;
  logic        rst;
  logic        cts_n;
  logic        txd;
  logic [31:0] data_count;
  int          total = 0;
  int          bad   = 0;

  uart_word_tx_if bus ();

  uart_word_tx #(
    .CLK_PER_HALF_BIT (2),
    .FIFO_AW          (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .i_cts_n      (cts_n),
    .o_txd        (txd),
    .o_data_count (data_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receives one frame by mid-bit sampling; optionally raises cts_n after a data bit.
  task automatic rx_byte(input int raise_at, output logic [7:0] b, output int waited);
    int n = 0;
    b = '0;
    while (txd !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    chk("start_seen", txd, 1'b0);
    repeat (2) @(negedge clk);
    chk("start_bit", txd, 1'b0);
    for (int k = 0; k < 8; k++) begin
      repeat (4) @(negedge clk);
      b[k] = txd;
      if (k == raise_at) cts_n = 1'b1;
    end
    repeat (4) @(negedge clk);
    chk("stop_bit", txd, 1'b1);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.output_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus.output_ready, 1'b1);
  endtask

  initial begin
    logic [9:0]  frame;
    logic [7:0]  b;
    int          w;
    logic        seen_low;
    logic [7:0]  exp4 [4];

    rst = 1'b1;
    cts_n = 1'b0;
    bus.send_data = '0;
    bus.core_sig = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1'b1);
    chk("rst_count", data_count, 32'd0);
    chk("rst_stall", bus.output_stall, 1'b0);
    chk("rst_ready", bus.output_ready, 1'b1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1-byte 0x99, exact cycle timing
    bus.core_sig = 2'b10;
    bus.send_data = 32'h0000_0099;
    @(negedge clk);
    bus.core_sig = 2'b00;
    chk("t1_idle_cycle", txd, 1'b1);
    frame = 10'b11_0011_0010;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("t1_bit", txd, frame[i/4]);
      if (i == 0)  chk("t1_busy", bus.output_ready, 1'b0);
      if (i == 39) chk("t1_count_before_stop_end", data_count, 32'd0);
    end
    @(negedge clk);
    chk("t1_count", data_count, 32'd1);
    @(negedge clk);
    chk("t1_ready", bus.output_ready, 1'b1);

    // 4-byte 0x11223344, little-endian, back-to-back
    bus.core_sig = 2'b11;
    bus.send_data = 32'h1122_3344;
    @(negedge clk);
    bus.core_sig = 2'b00;
    exp4[0] = 8'h44; exp4[1] = 8'h33; exp4[2] = 8'h22; exp4[3] = 8'h11;
    for (int i = 0; i < 4; i++) begin
      rx_byte(-1, b, w);
      chk("t2_byte", b, exp4[i]);
      if (i > 0) chk("t2_gap_ok", (w <= 4), 1'b1);
    end
    wait_ready("t2_ready");
    chk("t2_count", data_count, 32'd5);

    // Fill with cts_n high, 17th push dropped
    cts_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      if (i == 15) chk("t3_stall_at_15", bus.output_stall, 1'b0);
      if (i == 16) chk("t3_stall_at_16", bus.output_stall, 1'b1);
      bus.core_sig = 2'b10;
      bus.send_data = 32'(i);
      @(negedge clk);
    end
    bus.send_data = 32'h0000_00EE;
    seen_low = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (txd !== 1'b1 || bus.output_stall !== 1'b1) seen_low = 1'b1;
      @(negedge clk);
    end
    chk("t3_held_idle_full", seen_low, 1'b0);
    // Release: pop at full concurrent with a still-asserted push
    cts_n = 1'b0;
    @(negedge clk);
    chk("t3_stall_sync1", bus.output_stall, 1'b1);
    @(negedge clk);
    chk("t3_stall_sync2", bus.output_stall, 1'b1);
    @(negedge clk);
    chk("t3_stall_after_pop", bus.output_stall, 1'b0);
    chk("t3_start_after_pop", txd, 1'b0);
    bus.core_sig = 2'b00;
    for (int i = 0; i < 16; i++) begin
      rx_byte(-1, b, w);
      chk("t3_byte", b, 8'(i));
    end
    wait_ready("t3_ready");
    chk("t3_count", data_count, 32'd21);

    // cts_n raised mid byte 2 of a word
    bus.core_sig = 2'b11;
    bus.send_data = 32'hA5C3_0F5A;
    @(negedge clk);
    bus.core_sig = 2'b00;
    rx_byte(-1, b, w);
    chk("t4_byte1", b, 8'h5A);
    rx_byte(3, b, w);
    chk("t4_byte2", b, 8'h0F);
    seen_low = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) seen_low = 1'b1;
    end
    chk("t4_paused_high", seen_low, 1'b0);
    chk("t4_count_paused", data_count, 32'd23);
    cts_n = 1'b0;
    rx_byte(-1, b, w);
    chk("t4_byte3", b, 8'hC3);
    rx_byte(-1, b, w);
    chk("t4_byte4", b, 8'hA5);
    wait_ready("t4_ready");
    chk("t4_count", data_count, 32'd25);

    // Reset during DATA of a byte, then a clean frame
    bus.core_sig = 2'b10;
    bus.send_data = 32'h0000_003C;
    @(negedge clk);
    bus.core_sig = 2'b00;
    w = 0;
    while (txd !== 1'b0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_txd", txd, 1'b1);
    chk("t5_count", data_count, 32'd0);
    chk("t5_ready", bus.output_ready, 1'b1);
    chk("t5_stall", bus.output_stall, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    bus.core_sig = 2'b10;
    bus.send_data = 32'h0000_0081;
    @(negedge clk);
    bus.core_sig = 2'b00;
    rx_byte(-1, b, w);
    chk("t5_clean_byte", b, 8'h81);
    wait_ready("t5_ready_after");
    chk("t5_count_after", data_count, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
